// File: rtl/riscv_boot_loader.sv
// rtl/riscv_boot_loader.sv - loads a length-prefixed little-endian word image from a byte stream into imem, then releases the core.
module riscv_boot_loader #(
  parameter int IMEM_DEPTH_WORDS = 4096,
  parameter int TIMEOUT_CYCLES   = 1000000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  rx_data_in,
  input  logic        rx_valid_in,
  input  logic        load_req_in,
  output logic [31:0] imem_addr_out,
  output logic [31:0] imem_data_out,
  output logic        imem_we_out,
  output logic        core_rst_out,
  output logic        busy_out,
  output logic        error_out,
  output logic [31:0] words_loaded_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_LEN, S_LOAD, S_FLUSH, S_RUN, S_ERROR} state_t;

  state_t        state, state_n;
  logic [1:0]    byte_idx;
  logic [31:0]   shift_q;
  logic [31:0]   len_q;
  logic [TW-1:0] tmo_cnt;
  logic [31:0]   asm_word;
  logic          last_byte;
  logic          counting;
  logic          tmo_hit;

  // Bytes arrive LSB first, so each new byte enters at the top and the word settles after four.
  assign asm_word  = {rx_data_in, shift_q[31:8]};
  assign last_byte = rx_valid_in && (byte_idx == 2'd3);
  assign counting  = (state == S_LOAD) || ((state == S_LEN) && (byte_idx != 2'd0));
  assign tmo_hit   = counting && !rx_valid_in && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n = state;
    case (state)
      S_LEN: begin
        if (last_byte) begin
          if (asm_word == 32'd0)                       state_n = S_RUN;
          else if (asm_word > 32'(IMEM_DEPTH_WORDS))   state_n = S_ERROR;
          else                                         state_n = S_LOAD;
        end else if (tmo_hit) begin
          state_n = S_ERROR;
        end
      end
      S_LOAD: begin
        if (last_byte && (words_loaded_out == len_q - 32'd1)) state_n = S_FLUSH;
        else if (tmo_hit)                                      state_n = S_ERROR;
      end
      S_FLUSH: state_n = S_RUN;
      S_RUN, S_ERROR: if (load_req_in) state_n = S_LEN;
      default: state_n = S_LEN;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= S_LEN;
      byte_idx         <= 2'd0;
      shift_q          <= 32'd0;
      len_q            <= 32'd0;
      tmo_cnt          <= '0;
      imem_addr_out    <= 32'd0;
      imem_data_out    <= 32'd0;
      imem_we_out      <= 1'b0;
      core_rst_out     <= 1'b1;
      busy_out         <= 1'b1;
      error_out        <= 1'b0;
      words_loaded_out <= 32'd0;
    end else begin
      state        <= state_n;
      core_rst_out <= (state_n != S_RUN);
      busy_out     <= (state_n == S_LEN) || (state_n == S_LOAD) || (state_n == S_FLUSH);
      error_out    <= (state_n == S_ERROR);
      imem_we_out  <= 1'b0;

      if (((state == S_LEN) || (state == S_LOAD)) && rx_valid_in) begin
        shift_q  <= asm_word;
        byte_idx <= byte_idx + 2'd1;
        tmo_cnt  <= '0;
        if (byte_idx == 2'd3) begin
          if (state == S_LEN) begin
            len_q <= asm_word;
          end else begin
            imem_we_out      <= 1'b1;
            imem_addr_out    <= {words_loaded_out[29:0], 2'b00};
            imem_data_out    <= asm_word;
            words_loaded_out <= words_loaded_out + 32'd1;
          end
        end
      end else if (state_n != state) begin
        tmo_cnt <= '0;
      end else if (counting) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      // A reload starts from a clean byte alignment and an empty count.
      if (((state == S_RUN) || (state == S_ERROR)) && load_req_in) begin
        byte_idx         <= 2'd0;
        words_loaded_out <= 32'd0;
      end
    end
  end

endmodule
